// File: rtl/class_hv_stream.sv
// Class hypervector store that streams entries 0..N-1 to the associative memory over valid/ready.
// Optional macro CLASS_HV_WR_BYPASS_EN forwards a same-cycle write into the output register load.
module class_hv_stream #(
  parameter int unsigned HVDimension = 512,
  parameter int unsigned DataWidth   = 8,
  parameter int unsigned NumClass    = 32,
  parameter int unsigned AddrWidth   = (NumClass > 1) ? $clog2(NumClass) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   class_wr_en_i,
  input  logic [AddrWidth-1:0]   class_wr_addr_i,
  input  logic [HVDimension-1:0] class_wr_data_i,
  input  logic                   stream_start_i,
  input  logic [DataWidth-1:0]   am_num_class_i,
  output logic                   stream_busy_o,
  output logic [HVDimension-1:0] class_hv_o,
  output logic [DataWidth-1:0]   class_idx_o,
  output logic                   class_hv_valid_o,
  input  logic                   class_hv_ready_i
);

  localparam logic StIdle   = 1'b0;
  localparam logic StStream = 1'b1;

  logic [HVDimension-1:0] r_mem [NumClass];

  logic                   r_state;
  logic [HVDimension-1:0] r_hv;
  logic [DataWidth-1:0]   r_idx;
  logic [DataWidth-1:0]   r_ptr;
  logic [DataWidth-1:0]   r_n_eff;

  logic                   w_state_d;
  logic [HVDimension-1:0] w_hv_d;
  logic [DataWidth-1:0]   w_idx_d;
  logic [DataWidth-1:0]   w_ptr_d;
  logic [DataWidth-1:0]   w_n_eff_d;
  logic                   w_load;
  logic [AddrWidth-1:0]   w_load_addr;
  logic [HVDimension-1:0] w_load_data;
  logic [DataWidth-1:0]   w_n_eff;
  logic                   w_wr_ok;
  logic                   w_hs;
  logic                   w_last;

  assign w_wr_ok = (32'(class_wr_addr_i) < NumClass);
  assign w_n_eff = (32'(am_num_class_i) > NumClass) ? DataWidth'(NumClass) : am_num_class_i;
  assign w_hs    = r_state & class_hv_ready_i;
  assign w_last  = (r_idx == (r_n_eff - DataWidth'(1)));

  always_ff @(posedge clk_i) begin
    if (class_wr_en_i && w_wr_ok) begin
      r_mem[class_wr_addr_i] <= class_wr_data_i;
    end
  end

`ifdef CLASS_HV_WR_BYPASS_EN
  logic w_wr_hit;
  assign w_wr_hit    = class_wr_en_i && w_wr_ok && (class_wr_addr_i == w_load_addr);
  assign w_load_data = w_wr_hit ? class_wr_data_i : r_mem[w_load_addr];
`else
  // Load sees the array content from before any same-cycle write.
  assign w_load_data = r_mem[w_load_addr];
`endif

  always_comb begin
    w_state_d   = r_state;
    w_idx_d     = r_idx;
    w_ptr_d     = r_ptr;
    w_n_eff_d   = r_n_eff;
    w_load      = 1'b0;
    w_load_addr = '0;
    case (r_state)
      StIdle: begin
        if (stream_start_i && (am_num_class_i != '0)) begin
          w_state_d = StStream;
          w_load    = 1'b1;
          w_idx_d   = '0;
          w_ptr_d   = DataWidth'(1);
          w_n_eff_d = w_n_eff;
        end
      end
      StStream: begin
        if (w_hs) begin
          if (w_last) begin
            w_state_d = StIdle;
          end else begin
            w_load      = 1'b1;
            w_load_addr = AddrWidth'(r_ptr);
            w_idx_d     = r_ptr;
            w_ptr_d     = r_ptr + DataWidth'(1);
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign w_hv_d = w_load ? w_load_data : r_hv;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= StIdle;
      r_hv    <= '0;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_n_eff <= '0;
    end else begin
      r_state <= w_state_d;
      r_hv    <= w_hv_d;
      r_idx   <= w_idx_d;
      r_ptr   <= w_ptr_d;
      r_n_eff <= w_n_eff_d;
    end
  end

  // Valid and busy are both the registered STREAM state.
  assign stream_busy_o    = r_state;
  assign class_hv_valid_o = r_state;
  assign class_hv_o       = r_hv;
  assign class_idx_o      = r_idx;

endmodule

// File: tb/tb_class_hv_stream.sv
// Directed self-checking bench for class_hv_stream; follows CLASS_HV_WR_BYPASS_EN if defined.
module tb_class_hv_stream;

  localparam int unsigned HvW = 512;
  localparam int unsigned DW  = 8;
  localparam int unsigned NC  = 32;
  localparam int unsigned AW  = 5;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic           class_wr_en_i;
  logic [AW-1:0]  class_wr_addr_i;
  logic [HvW-1:0] class_wr_data_i;
  logic           stream_start_i;
  logic [DW-1:0]  am_num_class_i;
  logic           stream_busy_o;
  logic [HvW-1:0] class_hv_o;
  logic [DW-1:0]  class_idx_o;
  logic           class_hv_valid_o;
  logic           class_hv_ready_i;

  class_hv_stream #(
    .HVDimension(HvW),
    .DataWidth  (DW),
    .NumClass   (NC)
  ) u_dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .class_wr_en_i   (class_wr_en_i),
    .class_wr_addr_i (class_wr_addr_i),
    .class_wr_data_i (class_wr_data_i),
    .stream_start_i  (stream_start_i),
    .am_num_class_i  (am_num_class_i),
    .stream_busy_o   (stream_busy_o),
    .class_hv_o      (class_hv_o),
    .class_idx_o     (class_idx_o),
    .class_hv_valid_o(class_hv_valid_o),
    .class_hv_ready_i(class_hv_ready_i)
  );

  always #5 clk_i = ~clk_i;

  logic [HvW-1:0] model [NC];
  int n_vec = 0;
  int n_err = 0;
  int hs;
  int rdy_seq [5] = '{1, 0, 0, 1, 1};
  int idx_seq [5] = '{0, 1, 1, 1, 2};
  logic [HvW-1:0] new1;
  logic [HvW-1:0] new2;
  logic [HvW-1:0] exp_hv;

  function automatic logic [HvW-1:0] pat(input int k);
    logic [31:0] w;
    w = 32'(k + 1);
    return {16{w}};
  endfunction

  task automatic chk_vb(input string tag, input logic ev);
    n_vec++;
    assert ({class_hv_valid_o, stream_busy_o} === {ev, ev}) else begin
      n_err++;
      $error("FAIL %s valid/busy: got %b/%b expected %b/%b", tag, class_hv_valid_o,
             stream_busy_o, ev, ev);
    end
  endtask

  task automatic chk(input string tag, input logic ev, input logic [DW-1:0] ei,
                     input logic [HvW-1:0] eh);
    chk_vb(tag, ev);
    n_vec++;
    assert (class_idx_o === ei) else begin
      n_err++;
      $error("FAIL %s idx: got %0d expected %0d", tag, class_idx_o, ei);
    end
    n_vec++;
    assert (class_hv_o === eh) else begin
      n_err++;
      $error("FAIL %s hv: got %h expected %h", tag, class_hv_o, eh);
    end
  endtask

  initial begin
    class_wr_en_i    = 1'b0;
    class_wr_addr_i  = '0;
    class_wr_data_i  = '0;
    stream_start_i   = 1'b0;
    am_num_class_i   = '0;
    class_hv_ready_i = 1'b0;
    new1 = {16{32'h5A5A_0001}};
    new2 = {16{32'hA5A5_0002}};

    #12;
    chk("reset", 1'b0, '0, '0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int k = 0; k < int'(NC); k++) begin
      @(negedge clk_i);
      class_wr_en_i   = 1'b1;
      class_wr_addr_i = AW'(k);
      class_wr_data_i = pat(k);
      model[k]        = pat(k);
    end
    @(negedge clk_i);
    class_wr_en_i = 1'b0;

    // N=4, ready held high, then restart in the cycle after the last handshake
    stream_start_i   = 1'b1;
    am_num_class_i   = 8'd4;
    class_hv_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      stream_start_i = 1'b0;
      chk($sformatf("n4 beat%0d", k), 1'b1, DW'(k), model[k]);
    end
    @(negedge clk_i);
    chk("n4 end", 1'b0, 8'd3, model[3]);
    stream_start_i = 1'b1;
    am_num_class_i = 8'd2;
    @(negedge clk_i);
    stream_start_i = 1'b0;
    chk("restart beat0", 1'b1, 8'd0, model[0]);
    @(negedge clk_i);
    chk("restart beat1", 1'b1, 8'd1, model[1]);
    @(negedge clk_i);
    chk_vb("restart end", 1'b0);

    // Start pulsed mid-stream must be ignored
    stream_start_i = 1'b1;
    am_num_class_i = 8'd4;
    @(negedge clk_i);
    stream_start_i = 1'b0;
    chk("midstart beat0", 1'b1, 8'd0, model[0]);
    @(negedge clk_i);
    chk("midstart beat1", 1'b1, 8'd1, model[1]);
    stream_start_i = 1'b1;
    am_num_class_i = 8'd2;
    @(negedge clk_i);
    stream_start_i = 1'b0;
    chk("midstart beat2", 1'b1, 8'd2, model[2]);
    @(negedge clk_i);
    chk("midstart beat3", 1'b1, 8'd3, model[3]);
    @(negedge clk_i);
    chk_vb("midstart end", 1'b0);

    // N=3 with ready pattern 1,0,0,1,1
    stream_start_i = 1'b1;
    am_num_class_i = 8'd3;
    hs = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      stream_start_i   = 1'b0;
      class_hv_ready_i = (rdy_seq[c] != 0);
      chk($sformatf("toggle c%0d", c), 1'b1, DW'(idx_seq[c]), model[idx_seq[c]]);
      if (class_hv_valid_o && class_hv_ready_i) hs++;
    end
    @(negedge clk_i);
    chk_vb("toggle end", 1'b0);
    n_vec++;
    assert (hs == 3) else begin
      n_err++;
      $error("FAIL toggle handshakes: got %0d expected 3", hs);
    end

    // Count clamped to NumClass
    class_hv_ready_i = 1'b1;
    stream_start_i   = 1'b1;
    am_num_class_i   = 8'd40;
    for (int k = 0; k < int'(NC); k++) begin
      @(negedge clk_i);
      stream_start_i = 1'b0;
      chk($sformatf("n40 beat%0d", k), 1'b1, DW'(k), model[k]);
    end
    @(negedge clk_i);
    chk("n40 end", 1'b0, 8'd31, model[31]);

    // Zero count is ignored
    stream_start_i = 1'b1;
    am_num_class_i = 8'd0;
    @(negedge clk_i);
    stream_start_i = 1'b0;
    chk_vb("n0 cycle1", 1'b0);
    @(negedge clk_i);
    chk_vb("n0 cycle2", 1'b0);

    // Write addr 2 during the handshake on idx 1
    stream_start_i = 1'b1;
    am_num_class_i = 8'd3;
    @(negedge clk_i);
    stream_start_i = 1'b0;
    chk("byp beat0", 1'b1, 8'd0, model[0]);
    @(negedge clk_i);
    chk("byp beat1", 1'b1, 8'd1, model[1]);
    class_wr_en_i   = 1'b1;
    class_wr_addr_i = 5'd2;
    class_wr_data_i = new2;
    @(negedge clk_i);
    class_wr_en_i = 1'b0;
`ifdef CLASS_HV_WR_BYPASS_EN
    exp_hv = new2;
`else
    exp_hv = model[2];
`endif
    chk("byp beat2", 1'b1, 8'd2, exp_hv);
    model[2] = new2;
    @(negedge clk_i);
    chk_vb("byp end", 1'b0);

    // Write to the presented index while stalled
    stream_start_i = 1'b1;
    am_num_class_i = 8'd3;
    @(negedge clk_i);
    stream_start_i = 1'b0;
    chk("stall beat0", 1'b1, 8'd0, model[0]);
    @(negedge clk_i);
    chk("stall beat1", 1'b1, 8'd1, model[1]);
    class_hv_ready_i = 1'b0;
    class_wr_en_i    = 1'b1;
    class_wr_addr_i  = 5'd1;
    class_wr_data_i  = new1;
    @(negedge clk_i);
    class_wr_en_i = 1'b0;
    chk("stall held", 1'b1, 8'd1, model[1]);
    model[1]         = new1;
    class_hv_ready_i = 1'b1;
    @(negedge clk_i);
    chk("stall beat2", 1'b1, 8'd2, model[2]);
    @(negedge clk_i);
    chk_vb("stall end", 1'b0);

    // Asynchronous reset mid-stream
    stream_start_i = 1'b1;
    am_num_class_i = 8'd4;
    @(negedge clk_i);
    stream_start_i = 1'b0;
    chk("rst beat0", 1'b1, 8'd0, model[0]);
    @(negedge clk_i);
    chk("rst beat1", 1'b1, 8'd1, model[1]);
    @(negedge clk_i);
    chk("rst beat2", 1'b1, 8'd2, model[2]);
    rst_ni = 1'b0;
    #1;
    chk("rst async", 1'b0, '0, '0);
    @(negedge clk_i);
    chk("rst held", 1'b0, '0, '0);
    rst_ni         = 1'b1;
    stream_start_i = 1'b1;
    am_num_class_i = 8'd2;
    @(negedge clk_i);
    stream_start_i = 1'b0;
    chk("post rst beat0", 1'b1, 8'd0, model[0]);
    @(negedge clk_i);
    chk("post rst beat1", 1'b1, 8'd1, model[1]);
    @(negedge clk_i);
    chk_vb("post rst end", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
